multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control sequencer for the MIPS datapath. It replaces single-cycle opcode decoding with an FSM that steps each instruction through fetch, decode, execute, memory and writeback over several clocks on one shared memory port. It accepts memory wait states through a ready handshake, traps on unknown opcodes, and counts retired instructions. It sits beside the datapath and drives every mux select and write enable.

## Interface
- COUNT_W, 16, width of the retired-instruction counter
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  instruction[31:26] from the instruction register; sampled only in DECODE
- zero  in  1  ALU zero flag; used only in BRANCH
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_en  out  1  PC register write enable (branch condition already resolved)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread, memwrite  out  1 each  memory strobes
- irwrite  out  1  instruction register load
- memtoreg, regdst, regwrite  out  1 each  register-file controls
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- aluop  out  2  00 = add, 01 = sub, 10 = use funct field, 11 = set-less-than
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- trap  out  1  unknown opcode seen; sticky until reset
- state  out  4  current state encoding, for debug
- retire_count  out  COUNT_W  number of completed instructions; wraps modulo 2^COUNT_W

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, addi 001000, slti 001010, beq 000100, bne 000101, j 000010. Any other opcode is illegal.
- States and encodings: BOOT 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTEXE 7, RTWB 8, IEXE 9, IWB 10, BRANCH 11, JUMP 12, TRAP 13.
- Outputs are decoded from the current state. Any output not listed for a state is 0.
- BOOT: every output is 0. Always moves to FETCH.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pc_en equal mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target).
  - Next state by opcode: lw/sw → MEMADR, R-type → RTEXE, addi/slti → IEXE, beq/bne → BRANCH, j → JUMP, illegal → TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: lw → MEMRD, sw → MEMWR. The opcode is latched in DECODE.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then moves to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Retires the instruction; moves to FETCH.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready; retires when it completes; moves to FETCH.
- RTEXE: alusrca=1, alusrcb=00, aluop=10. Moves to RTWB.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Retires; moves to FETCH.
- IEXE: alusrca=1, alusrcb=10, aluop=00 for addi or 11 for slti. Moves to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Retires; moves to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pc_en = zero for beq; pc_en = ~zero for bne.
  - Retires; moves to FETCH.
- JUMP: pcsrc=10, pc_en=1. Retires; moves to FETCH.
- TRAP: trap=1 and every other output is 0. Stays in TRAP until reset; does not retire.
- Opcode latch: the 6-bit opcode is registered in DECODE and held until the next DECODE.
- retire_count increments by 1 on the clock edge that leaves a retiring state.

## Timing
- Reset: asserting rst_n immediately, with no clock needed, forces state=BOOT, retire_count=0, trap=0, latched opcode=0, and every output to 0.
  - Reset can be asserted in any state, including during a memory wait; it always overrides.
- After rst_n deasserts, the first rising edge enters FETCH.
- Cycle counts with mem_ready held at 1, counting FETCH through the last state:
  - lw 5
  - sw 4
  - R-type 4
  - addi/slti 4
  - beq/bne 3
  - j 3
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- memread and memwrite stay asserted, with iord stable, for the whole wait.
- pc_en in FETCH and BRANCH, and irwrite in FETCH, are combinational (mem_ready→irwrite/pc_en, zero→pc_en). All other outputs are Moore outputs, glitch-free relative to state.
- At most one of memread and memwrite is asserted in any cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode localparams
  - state encodings
  - aluop, alusrcb and pcsrc code constants
- Sub-module mc_opcode_class: purely combinational opcode classification. Outputs is_rtype, is_mem, is_load, is_imm, is_slti, is_branch, is_bne, is_jump, is_illegal.
- The top level holds:
  - state register
  - opcode latch
  - retire counter
  - trap flag
  - next-state and output decode

## Test plan
- Reset, then lw with mem_ready=1: state sequence 0,1,2,3,4,5,1. In MEMWB, regwrite=1, memtoreg=1 and regdst=0. retire_count goes 0→1 on the edge leaving MEMWB.
- beq with zero=1: in BRANCH, pc_en=1 and pcsrc=01. beq with zero=0: pc_en=0. bne with zero=0: pc_en=1. Each takes 3 cycles.
- FETCH with mem_ready=0 for 3 cycles: memread=1, irwrite=0 and pc_en=0 for those 3 cycles. On the 4th cycle (mem_ready=1), irwrite=pc_en=1, then the FSM moves to DECODE.
- Opcode 111111: FSM enters TRAP and trap=1. It stays there for 20 cycles, retire_count is unchanged, and rst_n low clears trap to 0 and state to BOOT.
- rst_n pulled low mid-MEMWR while memwrite=1 and mem_ready=0: memwrite drops before the next clock edge, and state reads 0.
- COUNT_W=4 with 17 consecutive j instructions: retire_count reaches 0xF after the 15th, wraps to 0x0 after the 16th, and reads 0x1 after the 17th.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: opcodes, FSM states,
// datapath select codes and the per-state Moore output decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_RTWB   = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       trap;
  } moore_t;

  // Outputs that depend only on the state (plus the latched slti bit in IEXE).
  function automatic moore_t moore_decode(state_t s, logic slti);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:  begin m.memread = 1'b1; m.alusrcb = SRCB_FOUR; m.aluop = ALU_ADD; m.pcsrc = PCSRC_ALU; end
      S_DECODE: begin m.alusrcb = SRCB_IMM_SH2; m.aluop = ALU_ADD; end
      S_MEMADR: begin m.alusrca = 1'b1; m.alusrcb = SRCB_IMM; end
      S_MEMRD:  begin m.memread = 1'b1; m.iord = 1'b1; end
      S_MEMWB:  begin m.regwrite = 1'b1; m.memtoreg = 1'b1; end
      S_MEMWR:  begin m.memwrite = 1'b1; m.iord = 1'b1; end
      S_RTEXE:  begin m.alusrca = 1'b1; m.alusrcb = SRCB_RT; m.aluop = ALU_FUNCT; end
      S_RTWB:   begin m.regwrite = 1'b1; m.regdst = 1'b1; end
      S_IEXE:   begin m.alusrca = 1'b1; m.alusrcb = SRCB_IMM; m.aluop = slti ? ALU_SLT : ALU_ADD; end
      S_IWB:    m.regwrite = 1'b1;
      S_BRANCH: begin m.alusrca = 1'b1; m.aluop = ALU_SUB; m.pcsrc = PCSRC_ALUOUT; end
      S_JUMP:   begin m.pcsrc = PCSRC_JUMP; m.pc_en = 1'b1; end
      S_TRAP:   m.trap = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational classification of a 6-bit MIPS opcode into instruction groups.
module mc_opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_imm,
  output logic       is_slti,
  output logic       is_branch,
  output logic       is_bne,
  output logic       is_jump,
  output logic       is_illegal
);

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_load    = (opcode == OP_LW);
  assign is_mem     = is_load | (opcode == OP_SW);
  assign is_slti    = (opcode == OP_SLTI);
  assign is_imm     = is_slti | (opcode == OP_ADDI);
  assign is_bne     = (opcode == OP_BNE);
  assign is_branch  = is_bne | (opcode == OP_BEQ);
  assign is_jump    = (opcode == OP_J);
  assign is_illegal = ~(is_rtype | is_mem | is_imm | is_branch | is_jump);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback on a shared memory port, traps on illegal opcodes, counts retirements.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               trap,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retire_count
);

  state_t               state_q, state_d;
  logic [5:0]           opcode_q, opcode_d;
  logic [COUNT_W-1:0]   count_q;
  moore_t               moore_q, moore_d;
  logic                 retire;

  logic is_rtype, is_mem, is_load, is_imm, is_slti, is_branch, is_bne, is_jump, is_illegal;

  // In DECODE the live opcode is classified; everywhere else the latched copy is.
  assign opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;

  mc_opcode_class u_class (
    .opcode     (opcode_d),
    .is_rtype   (is_rtype),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .is_imm     (is_imm),
    .is_slti    (is_slti),
    .is_branch  (is_branch),
    .is_bne     (is_bne),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_illegal)     state_d = S_TRAP;
        else if (is_mem)    state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_RTEXE;
        else if (is_imm)    state_d = S_IEXE;
        else if (is_branch) state_d = S_BRANCH;
        else if (is_jump)   state_d = S_JUMP;
      end
      S_MEMADR: state_d = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_IEXE:   state_d = S_IWB;
      S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_BOOT;
    endcase
    // Moore outputs are registered alongside the next state so they never glitch.
    moore_d = moore_decode(state_d, is_slti);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      opcode_q <= '0;
      count_q  <= '0;
      moore_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      moore_q  <= moore_d;
      if (retire) count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign irwrite = (state_q == S_FETCH) & mem_ready;
  assign pc_en   = moore_q.pc_en
                 | ((state_q == S_FETCH) & mem_ready)
                 | ((state_q == S_BRANCH) & (zero ^ is_bne));

  assign iord         = moore_q.iord;
  assign memread      = moore_q.memread;
  assign memwrite     = moore_q.memwrite;
  assign memtoreg     = moore_q.memtoreg;
  assign regdst       = moore_q.regdst;
  assign regwrite     = moore_q.regwrite;
  assign alusrca      = moore_q.alusrca;
  assign alusrcb      = moore_q.alusrcb;
  assign aluop        = moore_q.aluop;
  assign pcsrc        = moore_q.pcsrc;
  assign trap         = moore_q.trap;
  assign state        = state_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model of expected state
// sequences and per-state outputs, checked every cycle on two counter widths.
module tb_multicycle_ctrl;

  localparam int S_BOOT = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                 S_MEMWB = 5, S_MEMWR = 6, S_RTEXE = 7, S_RTWB = 8, S_IEXE = 9,
                 S_IWB = 10, S_BRANCH = 11, S_JUMP = 12, S_TRAP = 13;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h3f;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, trap;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic [15:0] cnt16;

  logic       pc_en4, iord4, memread4, memwrite4, irwrite4, memtoreg4, regdst4, regwrite4, alusrca4, trap4;
  logic [1:0] alusrcb4, aluop4, pcsrc4;
  logic [3:0] state4;
  logic [3:0] cnt4;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .trap(trap), .state(state),
    .retire_count(cnt16)
  );

  multicycle_ctrl #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en4), .iord(iord4), .memread(memread4), .memwrite(memwrite4), .irwrite(irwrite4),
    .memtoreg(memtoreg4), .regdst(regdst4), .regwrite(regwrite4), .alusrca(alusrca4),
    .alusrcb(alusrcb4), .aluop(aluop4), .pcsrc(pcsrc4), .trap(trap4), .state(state4),
    .retire_count(cnt4)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec, dut4_vec;
  assign dut_vec  = {pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
                     alusrca, alusrcb, aluop, pcsrc, trap};
  assign dut4_vec = {pc_en4, iord4, memread4, memwrite4, irwrite4, memtoreg4, regdst4, regwrite4,
                     alusrca4, alusrcb4, aluop4, pcsrc4, trap4};

  int          tests = 0;
  int          fails = 0;
  logic        chk = 1'b0;
  logic [15:0] exp_vec = '0;
  int          exp_st = 0;
  logic [15:0] exp_cnt = '0;
  int          retired = 0;
  logic [5:0]  lop = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic logic [15:0] exp_out(int st, logic [5:0] op, logic rdy, logic zr);
    logic pe, io, mr, mw, irw, m2r, rd, rw, asa, tr;
    logic [1:0] asb, aop, ps;
    {pe, io, mr, mw, irw, m2r, rd, rw, asa, tr} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pe = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; io = 1; end
      S_RTEXE:  begin asa = 1; aop = 2'b10; end
      S_RTWB:   begin rw = 1; rd = 1; end
      S_IEXE:   begin asa = 1; asb = 2'b10; aop = (op == OP_SLTI) ? 2'b11 : 2'b00; end
      S_IWB:    rw = 1;
      S_BRANCH: begin asa = 1; aop = 2'b01; ps = 2'b01; pe = (op == OP_BNE) ? ~zr : zr; end
      S_JUMP:   begin ps = 2'b10; pe = 1; end
      S_TRAP:   tr = 1;
      default:  ;
    endcase
    return {pe, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, tr};
  endfunction

  initial forever begin
    @(negedge clk);
    #2;
    if (chk) begin
      check("outputs", 32'(dut_vec), 32'(exp_vec));
      check("state", 32'(state), exp_st);
      check("count16", 32'(cnt16), 32'(exp_cnt));
      check("outputs4", 32'(dut4_vec), 32'(exp_vec));
      check("state4", 32'(state4), exp_st);
      check("count4", 32'(cnt4), 32'(exp_cnt[3:0]));
    end
  end

  // One clock of stimulus plus the model's expectation for that cycle.
  task automatic step(int st, logic rdy, logic zr, logic [5:0] opd, bit ret);
    logic r, z;
    @(negedge clk);
    r = (st == S_FETCH || st == S_MEMRD || st == S_MEMWR) ? rdy : 1'($urandom_range(0, 1));
    z = (st == S_BRANCH) ? zr : 1'($urandom_range(0, 1));
    mem_ready = r;
    zero      = z;
    opcode    = (st == S_DECODE) ? opd : 6'h3f;
    if (st == S_DECODE) lop = opd;
    exp_vec = exp_out(st, lop, r, z);
    exp_st  = st;
    exp_cnt = retired[15:0];
    chk     = 1'b1;
    if (ret) retired++;
  endtask

  task automatic do_instr(logic [5:0] op, logic zr, int fw, int mw);
    repeat (fw) step(S_FETCH, 1'b0, 1'b0, 6'h0, 1'b0);
    step(S_FETCH, 1'b1, 1'b0, 6'h0, 1'b0);
    step(S_DECODE, 1'b0, 1'b0, op, 1'b0);
    case (op)
      OP_LW: begin
        step(S_MEMADR, 1'b0, 1'b0, 6'h0, 1'b0);
        repeat (mw) step(S_MEMRD, 1'b0, 1'b0, 6'h0, 1'b0);
        step(S_MEMRD, 1'b1, 1'b0, 6'h0, 1'b0);
        step(S_MEMWB, 1'b0, 1'b0, 6'h0, 1'b1);
      end
      OP_SW: begin
        step(S_MEMADR, 1'b0, 1'b0, 6'h0, 1'b0);
        repeat (mw) step(S_MEMWR, 1'b0, 1'b0, 6'h0, 1'b0);
        step(S_MEMWR, 1'b1, 1'b0, 6'h0, 1'b1);
      end
      OP_R: begin
        step(S_RTEXE, 1'b0, 1'b0, 6'h0, 1'b0);
        step(S_RTWB, 1'b0, 1'b0, 6'h0, 1'b1);
      end
      OP_ADDI, OP_SLTI: begin
        step(S_IEXE, 1'b0, 1'b0, 6'h0, 1'b0);
        step(S_IWB, 1'b0, 1'b0, 6'h0, 1'b1);
      end
      OP_BEQ, OP_BNE: step(S_BRANCH, 1'b0, zr, 6'h0, 1'b1);
      OP_J:           step(S_JUMP, 1'b0, 1'b0, 6'h0, 1'b1);
      default:        step(S_TRAP, 1'b0, 1'b0, 6'h0, 1'b0);
    endcase
    $display("[TB] instr op=%b zero=%0d fetch_wait=%0d mem_wait=%0d retired_model=%0d",
             op, zr, fw, mw, retired);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_outputs", 32'(dut_vec), 0);
    check("rst_count16", 32'(cnt16), 0);
    check("rst_count4", 32'(cnt4), 0);
    retired = 0;
    lop = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h3f;
    exp_vec = '0;
    exp_st = S_BOOT;
    exp_cnt = '0;
    chk = 1'b1;
    $display("[TB] reset released");
  endtask

  initial begin
    do_reset();

    // lw: 0,1,2,3,4,5,1 with retire on leaving MEMWB
    step(S_FETCH, 1'b1, 1'b0, 6'h0, 1'b0);
    step(S_DECODE, 1'b0, 1'b0, OP_LW, 1'b0);
    step(S_MEMADR, 1'b0, 1'b0, 6'h0, 1'b0);
    step(S_MEMRD, 1'b1, 1'b0, 6'h0, 1'b0);
    step(S_MEMWB, 1'b0, 1'b0, 6'h0, 1'b1);
    #3;
    check("lw_regwrite", 32'(regwrite), 1);
    check("lw_memtoreg", 32'(memtoreg), 1);
    check("lw_regdst", 32'(regdst), 0);
    check("lw_count_before", 32'(cnt16), 0);
    #3;
    check("lw_count_after", 32'(cnt16), 1);
    check("lw_back_to_fetch", 32'(state), 1);
    $display("[TB] instr op=%b directed lw", OP_LW);

    do_instr(OP_BEQ, 1'b1, 0, 0);
    do_instr(OP_BEQ, 1'b0, 0, 0);
    do_instr(OP_BNE, 1'b0, 0, 0);
    do_instr(OP_BNE, 1'b1, 0, 0);

    // beq taken: hand-checked branch outputs
    step(S_FETCH, 1'b1, 1'b0, 6'h0, 1'b0);
    step(S_DECODE, 1'b0, 1'b0, OP_BEQ, 1'b0);
    step(S_BRANCH, 1'b0, 1'b1, 6'h0, 1'b1);
    #3;
    check("beq_taken_pc_en", 32'(pc_en), 1);
    check("beq_pcsrc", 32'(pcsrc), 1);
    zero = 1'b0;
    #1;
    check("beq_not_taken_pc_en", 32'(pc_en), 0);

    // FETCH held for 3 wait cycles before an R-type
    step(S_FETCH, 1'b0, 1'b0, 6'h0, 1'b0);
    #3;
    check("fetch_wait_irwrite", 32'(irwrite), 0);
    check("fetch_wait_memread", 32'(memread), 1);
    do_instr(OP_R, 1'b0, 2, 0);

    do_instr(OP_SW, 1'b0, 0, 2);
    do_instr(OP_LW, 1'b0, 1, 3);
    do_instr(OP_ADDI, 1'b0, 0, 0);
    do_instr(OP_SLTI, 1'b0, 0, 0);
    do_instr(OP_J, 1'b0, 0, 0);
    do_instr(OP_SW, 1'b0, 0, 0);
    do_instr(OP_R, 1'b0, 1, 0);

    // reset in the middle of a stalled store
    step(S_FETCH, 1'b1, 1'b0, 6'h0, 1'b0);
    step(S_DECODE, 1'b0, 1'b0, OP_SW, 1'b0);
    step(S_MEMADR, 1'b0, 1'b0, 6'h0, 1'b0);
    step(S_MEMWR, 1'b0, 1'b0, 6'h0, 1'b0);
    #3;
    check("memwr_before_reset", 32'(memwrite), 1);
    rst_n = 1'b0;
    #1;
    check("memwr_dropped", 32'(memwrite), 0);
    check("memwr_reset_state", 32'(state), 0);
    $display("[TB] instr op=%b reset during MEMWR", OP_SW);
    do_reset();

    // illegal opcode: trap, hold 20 cycles, no retirement
    do_instr(OP_ADDI, 1'b0, 0, 0);
    do_instr(OP_BAD, 1'b0, 0, 0);
    repeat (19) step(S_TRAP, 1'b0, 1'b0, 6'h0, 1'b0);
    #3;
    check("trap_flag", 32'(trap), 1);
    check("trap_count_held", 32'(cnt16), 1);
    do_reset();
    check("trap_cleared", 32'(trap), 0);

    // 17 jumps on the 4-bit counter: F after 15, 0 after 16, 1 after 17
    for (int k = 1; k <= 17; k++) begin
      do_instr(OP_J, 1'b0, 0, 0);
      #6;
      if (k == 15) check("wrap_after_15", 32'(cnt4), 32'hF);
      if (k == 16) check("wrap_after_16", 32'(cnt4), 32'h0);
      if (k == 17) check("wrap_after_17", 32'(cnt4), 32'h1);
    end
    check("count16_after_17", 32'(cnt16), 17);

    @(negedge clk);
    chk = 1'b0;
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
